// File: rtl/io_mmio_responder_pkg.sv
// Shared register map, status bit positions and address decode for the IO responder.
// Software headers and the core's memory decoder use the same offsets.
package io_mmio_responder_pkg;

  localparam logic [7:0] IO_UART_STAT = 8'h00;
  localparam logic [7:0] IO_UART_RX   = 8'h04;
  localparam logic [7:0] IO_UART_TX   = 8'h08;
  localparam logic [7:0] IO_CYC_CNT   = 8'h10;
  localparam logic [7:0] IO_INST_CNT  = 8'h14;
  localparam logic [7:0] IO_CNT_RST   = 8'h18;

  localparam int STAT_TX_READY   = 0;
  localparam int STAT_RX_VALID   = 1;
  localparam int STAT_TX_OVERRUN = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STAT,
    SEL_RX,
    SEL_TX,
    SEL_CYC,
    SEL_INST,
    SEL_CRST
  } io_sel_e;

  // Input is the word-aligned offset, zero-extended.
  function automatic io_sel_e io_decode(input logic [31:0] addr);
    io_sel_e sel;
    sel = SEL_NONE;
    if (addr == 32'(IO_UART_STAT)) sel = SEL_STAT;
    if (addr == 32'(IO_UART_RX))   sel = SEL_RX;
    if (addr == 32'(IO_UART_TX))   sel = SEL_TX;
    if (addr == 32'(IO_CYC_CNT))   sel = SEL_CYC;
    if (addr == 32'(IO_INST_CNT))  sel = SEL_INST;
    if (addr == 32'(IO_CNT_RST))   sel = SEL_CRST;
    return sel;
  endfunction

endpackage

// File: rtl/io_mmio_responder_if.sv
// Core-side load/store bus into the IO region.
interface io_mmio_responder_if #(
  parameter int ADDR_W = 8
);
  logic              io_en;
  logic              io_re;
  logic [3:0]        io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;

  modport master (
    output io_en, io_re, io_we, io_addr, io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_en, io_re, io_we, io_addr, io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/io_mmio_responder_fifo.sv
// Byte FIFO buffering UART RX data; push and pop may coincide in one cycle.
module io_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/io_mmio_responder.sv
// IO-region responder: UART RX FIFO / TX holding register, cycle and instruction
// counters, with load data registered one cycle later like the BRAM read path.
module io_mmio_responder
  import io_mmio_responder_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 4,
  parameter int ADDR_W        = 8,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_mmio_responder_if.slave   bus,
  input  logic                 i_inst_retired,
  input  logic [7:0]           i_uart_rx_data,
  input  logic                 i_uart_rx_valid,
  output logic                 o_uart_rx_ready,
  output logic [7:0]           o_uart_tx_data,
  output logic                 o_uart_tx_valid,
  input  logic                 i_uart_tx_ready
);
  logic [31:0]      r_rdata;
  logic             r_tx_full;
  logic [7:0]       r_tx_data;
  logic             r_tx_overrun;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_cnt;

  io_sel_e          w_sel;
  logic             w_rd;
  logic             w_stat_rd;
  logic             w_tx_wr;
  logic             w_tx_hs;
  logic             w_tx_accept;
  logic             w_cnt_clr;
  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [7:0]       w_fifo_data;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_val;
  logic             w_unused_bits;

  assign w_sel = bus.io_en ? io_decode(32'({bus.io_addr[ADDR_W-1:2], 2'b00})) : SEL_NONE;
  assign w_rd        = bus.io_en && bus.io_re;
  assign w_stat_rd   = w_rd && (w_sel == SEL_STAT);
  assign w_tx_wr     = (w_sel == SEL_TX) && bus.io_we[0];
  assign w_tx_hs     = r_tx_full && i_uart_tx_ready;
  assign w_tx_accept = w_tx_wr && (!r_tx_full || w_tx_hs);
  assign w_cnt_clr   = (w_sel == SEL_CRST) && (bus.io_we != 4'b0000);
  assign w_fifo_push = i_uart_rx_valid && o_uart_rx_ready;
  assign w_fifo_pop  = w_rd && (w_sel == SEL_RX) && !w_fifo_empty;

  assign o_uart_rx_ready = !w_fifo_full;
  assign o_uart_tx_valid = r_tx_full;
  assign o_uart_tx_data  = r_tx_data;
  assign bus.io_rdata    = r_rdata;

  // Byte-lane and sub-word address bits have no meaning in this map.
  assign w_unused_bits = ^{bus.io_addr[1:0], bus.io_wdata[31:8]};

  io_byte_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_data  (i_uart_rx_data),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_status                  = '0;
    w_status[STAT_TX_READY]   = !r_tx_full;
    w_status[STAT_RX_VALID]   = !w_fifo_empty;
    w_status[STAT_TX_OVERRUN] = r_tx_overrun;
  end

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_STAT: w_rd_val = w_status;
      SEL_RX:   w_rd_val = w_fifo_empty ? 32'h0 : {24'h0, w_fifo_data};
      SEL_CYC:  w_rd_val = 32'(r_cycle_cnt);
      SEL_INST: w_rd_val = 32'(r_inst_cnt);
      default:  w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rd_val;
    end
  end

  // A refill on the handshake edge keeps the holding register full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_full    <= 1'b0;
      r_tx_data    <= '0;
      r_tx_overrun <= 1'b0;
    end else begin
      if (w_tx_accept) begin
        r_tx_full <= 1'b1;
        r_tx_data <= bus.io_wdata[7:0];
      end else if (w_tx_hs) begin
        r_tx_full <= 1'b0;
      end
      if (w_tx_wr && !w_tx_accept) r_tx_overrun <= 1'b1;
      else if (w_stat_rd)          r_tx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (i_inst_retired) r_inst_cnt <= r_inst_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_io_mmio_responder.sv
// Directed and randomized checks of io_mmio_responder against a queue-based reference model.
module tb_io_mmio_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_mmio_responder_if #(.ADDR_W(8)) bus ();
  io_mmio_responder_if #(.ADDR_W(8)) bus8 ();

  logic       inst_retired = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       rx_ready8;
  logic [7:0] tx_data8;
  logic       tx_valid8;

  io_mmio_responder #(.RX_FIFO_DEPTH(4), .ADDR_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .i_inst_retired(inst_retired), .i_uart_rx_data(rx_data), .i_uart_rx_valid(rx_valid),
    .o_uart_rx_ready(rx_ready), .o_uart_tx_data(tx_data), .o_uart_tx_valid(tx_valid),
    .i_uart_tx_ready(tx_ready)
  );

  // Narrow counters make the all-ones -> 0 wrap reachable in a short run.
  io_mmio_responder #(.RX_FIFO_DEPTH(4), .ADDR_W(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8),
    .i_inst_retired(1'b0), .i_uart_rx_data(8'h00), .i_uart_rx_valid(1'b0),
    .o_uart_rx_ready(rx_ready8), .o_uart_tx_data(tx_data8), .o_uart_tx_valid(tx_valid8),
    .i_uart_tx_ready(1'b0)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  q[$];
  bit          m_tx_full;
  logic [7:0]  m_tx_data;
  bit          m_ovr;
  logic [31:0] m_cyc, m_inst, m_rdata, m_rdata8;
  logic [7:0]  m_cyc8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tx_full = 0; m_tx_data = 8'h00; m_ovr = 0;
    m_cyc = 0; m_inst = 0; m_rdata = 0; m_rdata8 = 0; m_cyc8 = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] wa);
    case (wa)
      8'h00:   return {29'b0, m_ovr, (q.size() != 0), !m_tx_full};
      8'h04:   return (q.size() != 0) ? {24'b0, q[0]} : 32'h0;
      8'h10:   return m_cyc;
      8'h14:   return m_inst;
      default: return 32'h0;
    endcase
  endfunction

  task automatic compare_all();
    chk("rdata", bus.io_rdata, m_rdata);
    chk("rx_ready", 32'(rx_ready), 32'(q.size() < 4));
    chk("tx_valid", 32'(tx_valid), 32'(m_tx_full));
    chk("tx_data", 32'(tx_data), 32'(m_tx_data));
    chk("cyc8_rdata", bus8.io_rdata, m_rdata8);
  endtask

  // Advance model and DUT by one clock using the inputs currently driven.
  task automatic step();
    logic [7:0] wa;
    bit rd, st, ready_pre, hs, wr, stat_rd;
    wa = bus.io_addr & 8'hFC;
    rd = bus.io_en && bus.io_re;
    st = bus.io_en && (bus.io_we != 4'b0000);
    ready_pre = (q.size() < 4);
    stat_rd = rd && (wa == 8'h00);
    if (rd) m_rdata = model_read(wa);
    if (rd && wa == 8'h04 && q.size() != 0) void'(q.pop_front());
    if (rx_valid && ready_pre) q.push_back(rx_data);
    hs = m_tx_full && tx_ready;
    wr = st && bus.io_we[0] && (wa == 8'h08);
    if (stat_rd) m_ovr = 0;
    if (wr) begin
      if (!m_tx_full || hs) begin m_tx_full = 1; m_tx_data = bus.io_wdata[7:0]; end
      else m_ovr = 1;
    end else if (hs) m_tx_full = 0;
    if (st && wa == 8'h18) begin
      m_cyc = 0; m_inst = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (inst_retired) m_inst = m_inst + 1;
    end
    m_rdata8 = {24'b0, m_cyc8};
    m_cyc8 = m_cyc8 + 8'd1;
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic bus_idle();
    bus.io_en = 0; bus.io_re = 0; bus.io_we = 4'b0000; bus.io_addr = 8'h00; bus.io_wdata = 32'h0;
  endtask

  task automatic do_idle();
    bus_idle();
    step();
  endtask

  task automatic do_rd(input logic [7:0] a);
    bus.io_en = 1; bus.io_re = 1; bus.io_we = 4'b0000; bus.io_addr = a;
    step();
    bus_idle();
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
    bus.io_en = 1; bus.io_re = 0; bus.io_we = we; bus.io_addr = a; bus.io_wdata = d;
    step();
    bus_idle();
  endtask

  logic [7:0] addrs [8];

  initial begin
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40};
    bus_idle();
    bus8.io_en = 1; bus8.io_re = 1; bus8.io_we = 4'b0000; bus8.io_addr = 8'h10; bus8.io_wdata = 32'h0;
    #12;
    chk("rst_rdata", bus.io_rdata, 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    model_reset();
    #10 rst_n = 1'b1;

    do_rd(8'h00);
    chk("stat_after_rst", bus.io_rdata, 32'h1);

    rx_valid = 1; rx_data = 8'h41; do_idle();
    rx_data = 8'h42; do_idle();
    rx_valid = 0;
    do_rd(8'h00); chk("stat_rx1", bus.io_rdata, 32'h3);
    do_rd(8'h04); chk("rx_0x41", bus.io_rdata, 32'h41);
    do_rd(8'h00); chk("stat_rx2", bus.io_rdata, 32'h3);
    do_rd(8'h04); chk("rx_0x42", bus.io_rdata, 32'h42);
    do_rd(8'h00); chk("stat_rx_empty", bus.io_rdata, 32'h1);
    do_rd(8'h04); chk("rx_empty", bus.io_rdata, 32'h0);

    rx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'($urandom_range(0, 255));
      do_idle();
    end
    chk("fifo_full_ready", 32'(rx_ready), 32'h0);
    do_rd(8'h04);
    chk("ready_after_pop", 32'(rx_ready), 32'h1);
    do_idle();
    chk("ready_refilled", 32'(rx_ready), 32'h0);
    rx_valid = 0;
    do_rd(8'h04);
    do_rd(8'h04);

    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", bus.io_rdata, 32'h0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    do_rd(8'h00);
    chk("stat_after_mid_rst", bus.io_rdata, 32'h1);

    tx_ready = 0;
    do_wr(8'h08, 32'hAABBCC55, 4'b0001);
    do_wr(8'h08, 32'h00000066, 4'b0001);
    chk("tx_hold", 32'(tx_data), 32'h55);
    do_wr(8'h08, 32'h00000077, 4'b1110);
    do_rd(8'h00); chk("stat_overrun", bus.io_rdata, 32'h4);
    do_rd(8'h00); chk("stat_overrun_clr", bus.io_rdata, 32'h0);
    tx_ready = 1;
    do_idle();
    chk("tx_handshake", 32'(tx_valid), 32'h0);

    bus.io_en = 0; bus.io_re = 0; bus.io_we = 4'b0001; bus.io_addr = 8'h08; bus.io_wdata = 32'h99;
    step();
    bus_idle();
    chk("tx_io_en_low", 32'(tx_valid), 32'h0);

    do_rd(8'h0C); chk("unmapped_0c", bus.io_rdata, 32'h0);
    do_rd(8'h40); chk("unmapped_40", bus.io_rdata, 32'h0);

    for (int i = 0; i < 1000 && m_cyc != 32'h122; i++) do_idle();
    do_rd(8'h10); chk("cyc_0x122", bus.io_rdata, 32'h122);
    do_wr(8'h18, 32'h0, 4'b0100);
    do_idle();
    do_rd(8'h10); chk("cyc_after_clr", bus.io_rdata, 32'h1);

    inst_retired = 1;
    for (int i = 0; i < 7; i++) do_idle();
    inst_retired = 0;
    do_rd(8'h14); chk("inst_7", bus.io_rdata, 32'h7);

    for (int i = 0; i < 400; i++) begin
      bus.io_en    = ($urandom_range(0, 3) != 0);
      bus.io_re    = $urandom_range(0, 1) == 1;
      bus.io_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
      bus.io_addr  = addrs[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
      bus.io_wdata = $urandom;
      rx_valid     = $urandom_range(0, 1) == 1;
      rx_data      = 8'($urandom_range(0, 255));
      tx_ready     = $urandom_range(0, 2) == 0;
      inst_retired = $urandom_range(0, 1) == 1;
      step();
    end
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
